// File: rtl/wb_regfile.sv
// wb_regfile: 32-entry integer register file between MEM/WB and ID/EX.
// One write port fed by MEM/WB, two registered read ports with stall hold,
// x0 hardwired to zero, and a combinational debug read of the committed array.
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> write-first: a read of the register being written returns wdata_i
//   undefined -> read-first : a read of the register being written returns the old value
module wb_regfile #(
  parameter int unsigned          XLEN     = 32,
  parameter logic [XLEN-1:0]      SP_RESET = 32'h0000_7FFC,
  parameter int unsigned          NREG     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            RegWrite_i,
  input  logic [4:0]      rd_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            hold_i,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o,
  input  logic [4:0]      dbg_addr_i,
  output logic [XLEN-1:0] dbg_data_o
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [XLEN-1:0] rdata1_q, rdata1_d;
  logic [XLEN-1:0] rdata2_q, rdata2_d;

  // A write commits only when enabled, aimed at a real register, and never at x0.
  logic wr_en;
  assign wr_en = RegWrite_i && (rd_i != 5'd0) && (int'(rd_i) < int'(NREG));

  // Architectural value seen by a read port on this edge, including x0 and
  // the same-edge write policy selected by REGFILE_BYPASS_EN.
  function automatic logic [XLEN-1:0] read_value(input logic [4:0] addr);
    if (addr == 5'd0 || int'(addr) >= int'(NREG)) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && rd_i == addr) return wdata_i;
`endif
    return regs_q[addr];
  endfunction

  // Next array contents: copy of the current array with at most one entry replaced.
  always_comb begin
    // NOTE: every always_comb output gets a full default first so no path
    // leaves it unassigned; that is what keeps synthesis from inferring a latch.
    regs_d = regs_q;
    if (wr_en) regs_d[rd_i] = wdata_i;
  end

  // Next read-port values: refresh from the array unless the pipeline is stalled.
  always_comb begin
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    if (!hold_i) begin
      rdata1_d = read_value(rs1_i);
      rdata2_d = read_value(rs2_i);
    end
  end

  // State update: register array and the two read-data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the array is deliberately reset (x2 holds the stack pointer at
      // boot), so it is built from flops, not an inferred RAM macro.
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= (i == 2) ? SP_RESET : '0;
      end
      rdata1_q <= '0;
      rdata2_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples the pre-edge values regardless of statement order.
      regs_q   <= regs_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
    end
  end

  assign rdata1_o = rdata1_q;
  assign rdata2_o = rdata2_q;

  // Debug read of the committed array: no bypass, zero for x0.
  always_comb begin
    dbg_data_o = '0;
    if (dbg_addr_i != 5'd0 && int'(dbg_addr_i) < int'(NREG)) dbg_data_o = regs_q[dbg_addr_i];
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed self-checking bench for wb_regfile.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_wb_regfile;

  localparam int XLEN = 32;
  localparam logic [31:0] SP_RESET = 32'h0000_7FFC;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            RegWrite_i;
  logic [4:0]      rd_i;
  logic [XLEN-1:0] wdata_i;
  logic            hold_i;
  logic [4:0]      rs1_i;
  logic [4:0]      rs2_i;
  logic [XLEN-1:0] rdata1_o;
  logic [XLEN-1:0] rdata2_o;
  logic [4:0]      dbg_addr_i;
  logic [XLEN-1:0] dbg_data_o;

  int checks   = 0;
  int failures = 0;

  wb_regfile #(.XLEN(XLEN), .SP_RESET(SP_RESET), .NREG(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RegWrite_i (RegWrite_i),
    .rd_i       (rd_i),
    .wdata_i    (wdata_i),
    .hold_i     (hold_i),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .rdata1_o   (rdata1_o),
    .rdata2_o   (rdata2_o),
    .dbg_addr_i (dbg_addr_i),
    .dbg_data_o (dbg_data_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] data);
    RegWrite_i = 1'b1;
    rd_i       = rd;
    wdata_i    = data;
    tick();
    RegWrite_i = 1'b0;
  endtask

  logic [31:0] exp_rdw;
  logic [31:0] exp_i;
  logic [31:0] exp_j;

  initial begin
    rst_n = 1'b1; RegWrite_i = 1'b0; rd_i = '0; wdata_i = '0;
    hold_i = 1'b0; rs1_i = '0; rs2_i = '0; dbg_addr_i = 5'd2;
    #2 rst_n = 1'b0;
    #1;
    // 1. reset state and first read
    check("rst_rdata1", rdata1_o, 32'h0);
    check("rst_rdata2", rdata2_o, 32'h0);
    check("rst_dbg_x2", dbg_data_o, SP_RESET);
    dbg_addr_i = 5'd5;
    #1 check("rst_dbg_x5", dbg_data_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rs1_i = 5'd2; rs2_i = 5'd5;
    tick();
    check("t1_rdata1_x2", rdata1_o, SP_RESET);
    check("t1_rdata2_x5", rdata2_o, 32'h0);
    dbg_addr_i = 5'd2;
    #1 check("t1_dbg_x2", dbg_data_o, SP_RESET);

    // 2. write x5, attempt to write x0, read both
    wr(5'd5, 32'hDEAD_BEEF);
    wr(5'd0, 32'h1234_5678);
    rs1_i = 5'd5; rs2_i = 5'd0;
    tick();
    check("t2_rdata1_x5", rdata1_o, 32'hDEAD_BEEF);
    check("t2_rdata2_x0", rdata2_o, 32'h0);
    dbg_addr_i = 5'd0;
    #1 check("t2_dbg_x0", dbg_data_o, 32'h0);
    // disabled write must not touch the array
    rd_i = 5'd5; wdata_i = 32'hBAD0_BAD0; RegWrite_i = 1'b0;
    tick();
    dbg_addr_i = 5'd5;
    #1 check("t2_we0_x5", dbg_data_o, 32'hDEAD_BEEF);

    // 3. read-during-write on x7
    wr(5'd7, 32'h1);
    rs1_i = 5'd7; rs2_i = 5'd7;
`ifdef REGFILE_BYPASS_EN
    exp_rdw = 32'hA5A5_A5A5;
`else
    exp_rdw = 32'h1;
`endif
    wr(5'd7, 32'hA5A5_A5A5);
    check("t3_rdw_rdata1", rdata1_o, exp_rdw);
    check("t3_rdw_rdata2", rdata2_o, exp_rdw);
    tick();
    check("t3_next_rdata1", rdata1_o, 32'hA5A5_A5A5);
    check("t3_next_rdata2", rdata2_o, 32'hA5A5_A5A5);

    // 4. hold
    wr(5'd3, 32'h11);
    wr(5'd4, 32'h44);
    rs1_i = 5'd3; rs2_i = 5'd5;
    tick();
    check("t4_latch_x3", rdata1_o, 32'h11);
    hold_i = 1'b1;
    rs1_i  = 5'd4;
    wr(5'd3, 32'h22);
    check("t4_hold1_rdata1", rdata1_o, 32'h11);
    tick();
    check("t4_hold2_rdata1", rdata1_o, 32'h11);
    tick();
    check("t4_hold3_rdata1", rdata1_o, 32'h11);
    check("t4_hold_rdata2", rdata2_o, 32'hDEAD_BEEF);
    dbg_addr_i = 5'd3;
    #1 check("t4_dbg_x3", dbg_data_o, 32'h22);
    hold_i = 1'b0;
    tick();
    check("t4_release_x4", rdata1_o, 32'h44);

    // 5. async reset between edges
    wr(5'd9, 32'hFF);
    rs1_i = 5'd9; rs2_i = 5'd9;
    tick();
    check("t5_pre_x9", rdata1_o, 32'hFF);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_rdata1", rdata1_o, 32'h0);
    check("t5_async_rdata2", rdata2_o, 32'h0);
    dbg_addr_i = 5'd9;
    #1 check("t5_async_dbg_x9", dbg_data_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rs1_i = 5'd9; rs2_i = 5'd2;
    tick();
    check("t5_post_x9", rdata1_o, 32'h0);
    check("t5_post_x2", rdata2_o, SP_RESET);

    // 6. sweep
    for (int i = 1; i < 32; i++) begin
      wr(5'(i), (32'(i) << 8) | 32'(i));
    end
    for (int i = 1; i < 32; i++) begin
      rs1_i = 5'(i); rs2_i = 5'(32 - i);
      exp_i = (32'(i) << 8) | 32'(i);
      exp_j = (32'(32 - i) << 8) | 32'(32 - i);
      tick();
      check($sformatf("t6_rs1_x%0d", i), rdata1_o, exp_i);
      check($sformatf("t6_rs2_x%0d", 32 - i), rdata2_o, exp_j);
    end
    rs1_i = 5'd0; rs2_i = 5'd0; dbg_addr_i = 5'd0;
    tick();
    check("t6_rs1_x0", rdata1_o, 32'h0);
    check("t6_rs2_x0", rdata2_o, 32'h0);
    check("t6_dbg_x0", dbg_data_o, 32'h0);
    dbg_addr_i = 5'd31;
    #1 check("t6_dbg_x31", dbg_data_o, 32'h0000_1F1F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- 32-entry integer register file for the 5-stage pipeline.
- Its write port is driven by the MEM/WB stage outputs (write enable, destination, write-back data).
- It has two synchronous read ports that feed the ID/EX stage.
- Reads are registered, with a stall hold; x0 is hardwired to zero; a combinational debug port is provided for the bench and the board display.

Parameters:
- XLEN, 32, data width of every register and data port.
- SP_RESET, 32'h0000_7FFC, reset value of x2 (stack pointer).
- NREG, 32, number of architectural registers (address width fixed at 5).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- RegWrite_i  input  1  write enable from MEM/WB.
- rd_i  input  5  write destination register from MEM/WB.
- wdata_i  input  XLEN  write-back data from MEM/WB.
- hold_i  input  1  stall: freeze read outputs this cycle.
- rs1_i  input  5  read address, port 1, from ID.
- rs2_i  input  5  read address, port 2, from ID.
- rdata1_o  output  XLEN  registered read data, port 1.
- rdata2_o  output  XLEN  registered read data, port 2.
- dbg_addr_i  input  5  debug read address.
- dbg_data_o  output  XLEN  combinational debug read of committed array.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low: asserting it clears state immediately, with no clock required.
- Reset values:
  - all registers 0, except x2 = SP_RESET
  - rdata1_o = rdata2_o = 0
  - dbg_data_o follows the array, so it reads 0 unless dbg_addr_i = 2
- Write:
  - On a rising clk edge with RegWrite_i=1 and rd_i!=0, reg[rd_i] <= wdata_i.
  - Writes to x0 are discarded.
  - RegWrite_i=0 leaves the array unchanged regardless of rd_i/wdata_i.
- Read latency is 1 cycle. On a rising edge with hold_i=0:
  - rdata1_o <= value(rs1_i)
  - rdata2_o <= value(rs2_i)
- value(a) is defined as follows:
  - a==0 gives 0, regardless of any write to x0.
  - a!=0 gives reg[a], subject to the read-during-write rule below.
- Read-during-write (same edge, RegWrite_i=1, rd_i==a, a!=0): governed by REGFILE_BYPASS_EN (see Optional Feature).
- Hold:
  - hold_i=1 keeps rdata1_o/rdata2_o at their previous values.
  - Writes still commit during hold.
  - A held output is not refreshed by a write to its address; it updates on the first edge with hold_i=0.
- Both read ports are independent: the same address on both ports returns identical data, and a bypass applies to both.
- Debug port: dbg_data_o = reg[dbg_addr_i], with 0 for address 0. It is purely combinational and has no bypass; it shows the new value after the write edge.
- Reset mid-operation: an in-flight write on the edge coincident with rst_n low is lost. Outputs go to reset values asynchronously.
- No X propagation: every output is driven at all times after reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-first. A read-during-write returns wdata_i in the same cycle, removing the WB→ID hazard without a forwarding path.
- Undefined: read-first. A read-during-write returns the old reg[a]; the new value is visible on the next read. The hazard unit must then cover the WB→ID distance.
- In both cases: x0 reads 0 and the array contents are identical.

Test Plan:
1. Reset then read: release rst_n, rs1=2, rs2=5, hold=0, 1 edge -> rdata1_o=32'h0000_7FFC, rdata2_o=0; dbg_addr=2 -> dbg_data_o=32'h0000_7FFC.
2. Write/read and x0 immunity:
   - Write x5=32'hDEAD_BEEF, then a separate edge writing x0=32'h1234_5678, then read rs1=5, rs2=0.
   - -> rdata1_o=32'hDEAD_BEEF, rdata2_o=0; dbg_addr=0 -> 0.
3. Read-during-write: x7 holds 32'h1; same edge RegWrite=1, rd=7, wdata=32'hA5A5_A5A5, rs1=rs2=7.
   - REGFILE_BYPASS_EN defined -> both outputs 32'hA5A5_A5A5.
   - Undefined -> both 32'h1; the next edge gives 32'hA5A5_A5A5.
4. Hold: rs1=3 (x3=32'h11) latched; assert hold_i, write x3=32'h22, change rs1=4 over 3 edges.
   - -> rdata1_o stays 32'h11 throughout; dbg shows x3=32'h22.
   - Deassert hold -> next edge rdata1_o=reg[4].
5. Async reset mid-run: write x9=32'hFF, then pull rst_n low between edges.
   - -> rdata outputs 0 immediately; after release, x9 reads 0 and x2 reads SP_RESET.
6. Sweep: write x1..x31 with value (i<<8)|i, then read all pairs (i, 32-i).
   - -> every output matches; x0 reads 0.
